patch_window_gen: RTL

- Parametrised successor to the clause patch-address generator for the convolutional Tsetlin machine datapath.
- Walks every patch position of an image of programmable size, patch size and stride in row-major order.
- Emits up to LANES horizontally adjacent patch positions per beat: coordinates plus thermometer masks for the clause PEs.
- Adds a start/busy/done command interface, a valid/ready output stream, config error detection, abort, and per-lane valid masking for partial final beats.

---
 rtl/patch_window_gen_if.sv | 40 ++++
 rtl/patch_window_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/patch_window_gen_if.sv
// Command, configuration and beat-stream bundle for patch_window_gen.
// The master modport is the generator's view; slave is the controller/consumer's view.
interface patch_window_gen_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned HEIGHT = 32,
  parameter int unsigned LANES  = 4,
  parameter int unsigned PMAX   = 7
);
  localparam int unsigned XW = $clog2(WIDTH) + 1;
  localparam int unsigned YW = $clog2(HEIGHT) + 1;
  localparam int unsigned SW = $clog2(PMAX + 1);

  logic                     start;
  logic                     abort;
  logic [SW-1:0]            patch_size;
  logic [SW-1:0]            stride;
  logic [XW-1:0]            image_width;
  logic [YW-1:0]            image_height;
  logic                     busy;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*XW-1:0]      patch_x;
  logic [YW-1:0]            patch_y;
  logic [LANES-1:0]         lane_valid;
  logic [LANES*WIDTH-1:0]   x_therm;
  logic [HEIGHT-1:0]        y_therm;
  logic                     last;
  logic                     done;
  logic                     err;

  modport master (
    input  start, abort, patch_size, stride, image_width, image_height, out_ready,
    output busy, out_valid, patch_x, patch_y, lane_valid, x_therm, y_therm, last, done, err
  );

  modport slave (
    output start, abort, patch_size, stride, image_width, image_height, out_ready,
    input  busy, out_valid, patch_x, patch_y, lane_valid, x_therm, y_therm, last, done, err
  );
endinterface

// File: rtl/patch_window_gen.sv
// Row-major patch-position walker for the convolutional Tsetlin machine clause PEs:
// emits up to LANES adjacent patch positions per beat with coordinate thermometers.
module patch_window_gen #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned HEIGHT = 32,
  parameter int unsigned LANES  = 4,
  parameter int unsigned PMAX   = 7
) (
  input  logic               clk,
  input  logic               rst,
  patch_window_gen_if.master bus
);
  localparam int unsigned XW = $clog2(WIDTH) + 1;
  localparam int unsigned YW = $clog2(HEIGHT) + 1;
  localparam int unsigned SW = $clog2(PMAX + 1);
  // Headroom so base + LANES*stride + patch never wraps, even for the largest encodable width.
  localparam int unsigned XA = $clog2((1 << XW) + (LANES + 1) * PMAX) + 1;
  localparam int unsigned YA = $clog2((1 << YW) + 2 * PMAX) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

  state_e                 state_q, state_d;
  logic [SW-1:0]          p_q, p_d, s_q, s_d;
  logic [XW-1:0]          w_q, w_d;
  logic [YW-1:0]          h_q, h_d;
  logic [XA-1:0]          xb_q, xb_d;
  logic [YA-1:0]          y_q, y_d;
  logic                   busy_q, busy_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   done_q, done_d;
  logic                   last_q, row_end_q;
  logic [LANES*XW-1:0]    px_q, px_b;
  logic [YW-1:0]          py_q;
  logic [LANES-1:0]       lv_q, lv_b;
  logic [LANES*WIDTH-1:0] xt_q, xt_b;
  logic [HEIGHT-1:0]      yt_q, yt_b;
  logic                   last_b, row_end_b;
  logic                   load_beat, clr_beat, cfg_bad;
  logic [XA-1:0]          step, lane_off, lane_x;

  assign cfg_bad = (bus.patch_size == '0) || (bus.stride == '0) ||
                   (bus.patch_size > SW'(PMAX)) || (bus.stride > SW'(PMAX)) ||
                   (XA'(bus.patch_size) > XA'(bus.image_width)) ||
                   (YA'(bus.patch_size) > YA'(bus.image_height));

  assign step = XA'(s_q) * XA'(LANES);

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    s_d       = s_q;
    w_d       = w_q;
    h_d       = h_q;
    xb_d      = xb_q;
    y_d       = y_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    err_d     = err_q;
    done_d    = 1'b0;
    load_beat = 1'b0;
    clr_beat  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (cfg_bad) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            p_d       = bus.patch_size;
            s_d       = bus.stride;
            w_d       = bus.image_width;
            h_d       = bus.image_height;
            xb_d      = '0;
            y_d       = '0;
            err_d     = 1'b0;
            busy_d    = 1'b1;
            valid_d   = 1'b1;
            load_beat = 1'b1;
            state_d   = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          valid_d  = 1'b0;
          clr_beat = 1'b1;
        end else if (valid_q && bus.out_ready) begin
          if (last_q) begin
            state_d  = S_FIN;
            busy_d   = 1'b0;
            valid_d  = 1'b0;
            done_d   = 1'b1;
            clr_beat = 1'b1;
          end else begin
            if (row_end_q) begin
              xb_d = '0;
              y_d  = y_q + YA'(s_q);
            end else begin
              xb_d = xb_q + step;
            end
            load_beat = 1'b1;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Beat contents are derived from the next-state position so they can be registered
  // in the same edge as the coordinates, keeping out_ready off every data path.
  always_comb begin
    px_b     = '0;
    lv_b     = '0;
    xt_b     = '0;
    yt_b     = '0;
    lane_off = '0;
    lane_x   = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      lane_x = xb_d + lane_off;
      if (lane_x + XA'(p_d) <= XA'(w_d)) begin
        lv_b[k]            = 1'b1;
        px_b[k*XW +: XW]   = lane_x[XW-1:0];
        for (int unsigned i = 0; i < WIDTH; i++) begin
          xt_b[k*WIDTH + i] = (XA'(i) < lane_x);
        end
      end
      lane_off = lane_off + XA'(s_d);
    end
    for (int unsigned i = 0; i < HEIGHT; i++) begin
      yt_b[i] = (YA'(i) < y_d);
    end
    row_end_b = (xb_d + lane_off + XA'(p_d)) > XA'(w_d);
    last_b    = row_end_b && ((y_d + YA'(s_d) + YA'(p_d)) > YA'(h_d));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      p_q       <= '0;
      s_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      xb_q      <= '0;
      y_q       <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      last_q    <= 1'b0;
      row_end_q <= 1'b0;
      px_q      <= '0;
      py_q      <= '0;
      lv_q      <= '0;
      xt_q      <= '0;
      yt_q      <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      s_q     <= s_d;
      w_q     <= w_d;
      h_q     <= h_d;
      xb_q    <= xb_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      done_q  <= done_d;
      if (load_beat) begin
        last_q    <= last_b;
        row_end_q <= row_end_b;
        px_q      <= px_b;
        py_q      <= y_d[YW-1:0];
        lv_q      <= lv_b;
        xt_q      <= xt_b;
        yt_q      <= yt_b;
      end else if (clr_beat) begin
        last_q    <= 1'b0;
        row_end_q <= 1'b0;
        px_q      <= '0;
        py_q      <= '0;
        lv_q      <= '0;
        xt_q      <= '0;
        yt_q      <= '0;
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.out_valid  = valid_q;
  assign bus.patch_x    = px_q;
  assign bus.patch_y    = py_q;
  assign bus.lane_valid = lv_q;
  assign bus.x_therm    = xt_q;
  assign bus.y_therm    = yt_q;
  assign bus.last       = last_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
endmodule
